// File: rtl/apb_spi_regs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_spi_pkg : register map, bit indices and access FSM encoding      |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package apb_spi_pkg;

  // Word offsets as seen on PADDR[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_OVF_CLR = 1;
  localparam int CTRL_DIV_LSB = 8;

  localparam int STAT_TX_EMPTY   = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_RX_EMPTY   = 2;
  localparam int STAT_RX_FULL    = 3;
  localparam int STAT_RX_OVF     = 4;
  localparam int STAT_SPI_BUSY   = 5;
  localparam int STAT_TX_CNT_LSB = 8;
  localparam int STAT_RX_CNT_LSB = 16;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_WAIT = 2'd1,
    ACC_DONE = 2'd2
  } acc_state_e;

endpackage
`default_nettype wire

// File: rtl/apb_spi_regs_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_spi_regs_if : APB3 bus bundle with master and slave views        |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
interface apb_spi_regs_if #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 32
);
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/apb_spi_regs_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, power-of-2 depth, zero head when empty|
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   push_i,
  input  wire logic [WIDTH-1:0]       data_i,
  input  wire logic                   pop_i,
  output logic      [WIDTH-1:0]       data_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic      [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule
`default_nettype wire

// File: rtl/apb_spi_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_spi_regs : APB3 register front-end for the SPI master core       |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module apb_spi_regs
  import apb_spi_pkg::*;
#(
  parameter int AWIDTH      = 4,
  parameter int DWIDTH      = 32,
  parameter int SPI_WIDTH   = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int WAIT_STATES = 0
) (
  input  wire logic                 PCLK,
  input  wire logic                 PRESETn,
  apb_spi_regs_if.slave             apb,
  output logic                      spi_en,
  output logic [7:0]                clk_div,
  output logic                      tx_valid,
  output logic [SPI_WIDTH-1:0]      tx_data,
  input  wire logic                 tx_ready,
  input  wire logic                 rx_valid,
  input  wire logic [SPI_WIDTH-1:0] rx_data,
  input  wire logic                 spi_busy
);
  localparam int         CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  acc_state_e     state_q, state_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic           access, pready, slv_err, complete, addr_ok, hi_zero;
  logic [1:0]     reg_sel;
  logic [DWIDTH-1:0] rdata;
  logic [31:0]    status_word;
  logic           spi_en_q, spi_en_d, rx_ovf_q, rx_ovf_d;
  logic [7:0]     clk_div_q, clk_div_d;
  logic           wr_ctrl, tx_push, tx_pop, rx_pop, rx_ovf_set;
  logic           tx_empty, tx_full, rx_empty, rx_full;
  logic [CW-1:0]  tx_count, rx_count;
  logic [SPI_WIDTH-1:0] rx_head;
  logic           unused_pwdata;

  assign access        = apb.PSEL & apb.PENABLE;
  assign reg_sel       = apb.PADDR[3:2];
  assign unused_pwdata = ^apb.PWDATA;

  generate
    if (AWIDTH > 4) begin : g_hi_addr
      assign hi_zero = ~|apb.PADDR[AWIDTH-1:4];
    end else begin : g_no_hi_addr
      assign hi_zero = 1'b1;
    end
  endgenerate

  assign addr_ok = hi_zero & (apb.PADDR[1:0] == 2'b00);

  // ---------------- access FSM ----------------
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= ACC_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // wcnt counts low-PREADY cycles already spent, the IDLE cycle included
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ACC_IDLE: begin
        wcnt_d = '0;
        if (access && (WS != 4'd0)) begin
          wcnt_d  = 4'd1;
          state_d = (WS == 4'd1) ? ACC_DONE : ACC_WAIT;
        end
      end
      ACC_WAIT: begin
        if (!apb.PSEL) begin
          state_d = ACC_IDLE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
          if (wcnt_d == WS) state_d = ACC_DONE;
        end
      end
      ACC_DONE: state_d = ACC_IDLE;
      default:  state_d = ACC_IDLE;
    endcase
  end

  always_comb begin
    pready      = access & (((WS == 4'd0) & (state_q == ACC_IDLE)) | (state_q == ACC_DONE));
    apb.PREADY  = pready;
    apb.PSLVERR = pready & slv_err;
    apb.PRDATA  = (pready & ~slv_err & ~apb.PWRITE) ? rdata : '0;
  end

  // ---------------- decode ----------------
  always_comb begin
    slv_err = 1'b0;
    if (!addr_ok) begin
      slv_err = 1'b1;
    end else begin
      case (reg_sel)
        REG_STATUS: slv_err = apb.PWRITE;
        REG_TXDATA: slv_err = apb.PWRITE & tx_full;
        REG_RXDATA: slv_err = apb.PWRITE | rx_empty;
        default:    slv_err = 1'b0;
      endcase
    end
  end

  always_comb begin
    status_word                               = '0;
    status_word[STAT_TX_EMPTY]                = tx_empty;
    status_word[STAT_TX_FULL]                 = tx_full;
    status_word[STAT_RX_EMPTY]                = rx_empty;
    status_word[STAT_RX_FULL]                 = rx_full;
    status_word[STAT_RX_OVF]                  = rx_ovf_q;
    status_word[STAT_SPI_BUSY]                = spi_busy;
    status_word[STAT_TX_CNT_LSB +: 4]         = 4'(tx_count);
    status_word[STAT_RX_CNT_LSB +: 4]         = 4'(rx_count);
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN]               = spi_en_q;
        rdata[CTRL_DIV_LSB +: 8]     = clk_div_q;
      end
      REG_STATUS: rdata = DWIDTH'(status_word);
      REG_RXDATA: rdata = DWIDTH'(rx_head);
      default:    rdata = '0;
    endcase
  end

  // ---------------- side effects on the completion edge ----------------
  assign complete   = pready & ~slv_err;
  assign wr_ctrl    = complete &  apb.PWRITE & (reg_sel == REG_CTRL);
  assign tx_push    = complete &  apb.PWRITE & (reg_sel == REG_TXDATA);
  assign rx_pop     = complete & ~apb.PWRITE & (reg_sel == REG_RXDATA);
  assign tx_pop     = tx_valid & tx_ready;
  assign rx_ovf_set = rx_valid & rx_full & ~rx_pop;

  always_comb begin
    spi_en_d  = spi_en_q;
    clk_div_d = clk_div_q;
    rx_ovf_d  = rx_ovf_q;
    if (wr_ctrl) begin
      spi_en_d  = apb.PWDATA[CTRL_EN];
      clk_div_d = apb.PWDATA[CTRL_DIV_LSB +: 8];
      if (apb.PWDATA[CTRL_OVF_CLR]) rx_ovf_d = 1'b0;
    end
    if (rx_ovf_set) rx_ovf_d = 1'b1;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      spi_en_q  <= 1'b0;
      clk_div_q <= '0;
      rx_ovf_q  <= 1'b0;
    end else begin
      spi_en_q  <= spi_en_d;
      clk_div_q <= clk_div_d;
      rx_ovf_q  <= rx_ovf_d;
    end
  end

  assign spi_en   = spi_en_q;
  assign clk_div  = clk_div_q;
  assign tx_valid = ~tx_empty;

  sync_fifo #(.WIDTH(SPI_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .push_i  (tx_push),
    .data_i  (apb.PWDATA[SPI_WIDTH-1:0]),
    .pop_i   (tx_pop),
    .data_o  (tx_data),
    .empty_o (tx_empty),
    .full_o  (tx_full),
    .count_o (tx_count)
  );

  sync_fifo #(.WIDTH(SPI_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .push_i  (rx_valid),
    .data_i  (rx_data),
    .pop_i   (rx_pop),
    .data_o  (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full),
    .count_o (rx_count)
  );
endmodule
`default_nettype wire

// File: doc/apb_spi_regs.md
# apb_spi_regs

APB3 slave front-end for the SPI master: decodes a four-word register map, buffers transmit and receive words in parametrised FIFOs, and exchanges data with the SPI shift core over valid/ready handshakes. It generalises the fixed zero-wait APB port with programmable wait states, real PSLVERR generation and configurable word width and FIFO depth. It sits between the APB interconnect and the SPI master core.

## Interface
- AWIDTH, 4, APB address width; must be at least 4.
- DWIDTH, 32, APB data width; must be at least 16.
- SPI_WIDTH, 8, SPI word width; must be at most DWIDTH.
- FIFO_DEPTH, 4, entries per FIFO; must be a power of 2 and at least 2.
- WAIT_STATES, 0, cycles PREADY is held low in each access phase; range 0..15.
- PCLK  in  1  single clock for all logic.
- PRESETn  in  1  reset; synchronous and active-low.
- PSEL, PENABLE, PWRITE  in  1 each  APB3 control.
- PADDR  in  AWIDTH  byte address.
- PWDATA  in  DWIDTH  write data.
- PRDATA  out  DWIDTH  read data.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  transfer error.
- spi_en  out  1  CTRL[0].
- clk_div  out  8  CTRL[15:8].
- tx_valid  out  1  TX FIFO is not empty.
- tx_data  out  SPI_WIDTH  TX FIFO head.
- tx_ready  in  1  core accepts tx_data.
- rx_valid  in  1  core delivers a received word; there is no backpressure.
- rx_data  in  SPI_WIDTH  received word.
- spi_busy  in  1  core is shifting.

## Operation
- Register map uses PADDR[3:2]; PADDR[1:0] and PADDR[AWIDTH-1:4] must be 0.
  - 0x0 CTRL, read/write: [0] enable, [1] ovf_clr (write-1, self-clearing, reads 0), [15:8] clk_div.
  - 0x4 STATUS, read-only: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] rx_ovf (sticky), [5] spi_busy, [11:8] tx_count, [19:16] rx_count. Counts are zero-extended or truncated to 4 bits.
  - 0x8 TXDATA, write-only: pushes PWDATA[SPI_WIDTH-1:0]. Reads return 0 with no error.
  - 0xC RXDATA, read-only: pops the RX head, zero-extended to DWIDTH.
- PSLVERR=1 in the completion cycle, with no side effect, for any of these:
  - misaligned or out-of-range address;
  - write to STATUS or RXDATA;
  - write to TXDATA when tx_full;
  - read of RXDATA when rx_empty, with PRDATA=0.
- Access FSM states: IDLE, WAIT, DONE.
  - IDLE->WAIT on PSEL&PENABLE when WAIT_STATES>0.
  - WAIT counts WAIT_STATES cycles, then goes to DONE.
  - DONE->IDLE unconditionally.
  - When WAIT_STATES=0 the FSM stays in IDLE and completion is combinational.
- Side effects (register write, push, pop, ovf_clr) happen only on the completion edge: PSEL&PENABLE&PREADY sampled high.
- TX handshake: an entry is popped on the edge where tx_valid&tx_ready.
- RX push on rx_valid:
  - if not full, push;
  - if full and not popped in the same cycle, drop the word and set rx_ovf;
  - if full and an APB pop happens in the same cycle, the push succeeds.
- rx_ovf clear and set in the same cycle: set wins.

## Timing
- Reset values: PRDATA=0, PREADY=0 when idle, PSLVERR=0, spi_en=0, clk_div=0, tx_valid=0, tx_data=0, both FIFOs empty, rx_ovf=0, FSM=IDLE.
- PREADY = PSEL&PENABLE&((WAIT_STATES==0 & state==IDLE) | state==DONE).
- PRDATA and PSLVERR are valid only while PREADY=1 and are 0 otherwise.
- Access-phase length is 1+WAIT_STATES cycles.
- Push-to-tx_valid latency: 1 cycle.
- STATUS reflects the registered state from before the current edge.
- Simultaneous push and pop on either FIFO: count is unchanged, and this is legal even when full or empty.
- Pointers wrap modulo FIFO_DEPTH. Counts are log2(FIFO_DEPTH)+1 bits wide.
- Deassertion of PSEL mid-WAIT returns the FSM to IDLE with no side effect.
- PRESETn low mid-transfer: next edge gives the reset state and drops FIFO contents.

## Structure
- Shared package apb_spi_pkg holds:
  - register offsets;
  - CTRL and STATUS bit indices;
  - the access FSM state enum.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), instantiated twice, for TX and RX.
- Decode, FSM and register logic stay in the top.

## Test plan
- Reset then read STATUS -> PRDATA=0x00000005, PSLVERR=0; read CTRL -> 0.
- WAIT_STATES=2: write CTRL=0x0301 -> PREADY low for 2 access cycles, then high; spi_en=1, clk_div=0x03.
- Write TXDATA 0x11,0x22,0x33,0x44 with tx_ready=0 -> tx_full=1, tx_count=4. A fifth write -> PSLVERR=1 and the FIFO is unchanged. Raise tx_ready -> tx_data appears in order 0x11..0x44.
- Read RXDATA when empty -> PSLVERR=1, PRDATA=0. Drive 5 rx_valid words -> rx_full=1, rx_ovf=1, first 4 words read back in order. Write CTRL[1]=1 -> rx_ovf=0.
- Access PADDR=0x2, and write STATUS -> PSLVERR=1 and no register changes.
- RX full, with an APB pop and rx_valid in the same cycle -> rx_count stays 4, rx_ovf stays 0. PRESETn low mid-WAIT -> all outputs return to reset values on the next edge.
